// File: rtl/fc_weight_loader_pkg.sv
// Shared FC geometry and loader FSM state definitions, used by both the
// weight loader and the weight buffer so the array shape has one source.
package fc_weight_loader_pkg;

  localparam int FC_ROWS  = 10;
  localparam int FC_COLS  = 9;
  localparam int FC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } fc_state_t;

  // Counter width that stays at least one bit for degenerate geometries.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_weight_loader_if.sv
// Byte-stream handshake plus assembled weight array between the fetch path
// (master) and the weight loader (slave).
interface fc_weight_loader_if
  import fc_weight_loader_pkg::*;
#(
  parameter int ROWS  = FC_ROWS,
  parameter int COLS  = FC_COLS,
  parameter int WIDTH = FC_WIDTH
);

  logic                                   i_start;
  logic                                   i_valid;
  logic [WIDTH-1:0]                       i_data;
  logic                                   o_ready;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]   o_weight;
  logic                                   o_weight_valid;
  logic                                   o_busy;

  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_weight, o_weight_valid, o_busy
  );

  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_weight, o_weight_valid, o_busy
  );

endinterface

// File: rtl/lib_reg.sv
// Generic enabled register with synchronous active-high clear; the common
// storage cell of the library.
module lib_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when enabled; clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fc_weight_loader.sv
// Assembles a row-major serial weight stream into the ROWS x COLS array the
// FC weight buffer consumes, flagging it valid once every entry is written.
module fc_weight_loader
  import fc_weight_loader_pkg::*;
#(
  parameter int ROWS  = FC_ROWS,
  parameter int COLS  = FC_COLS,
  parameter int WIDTH = FC_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fc_weight_loader_if.slave wf
);

  localparam int RW = cnt_width(ROWS);
  localparam int CW = cnt_width(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  fc_state_t         state_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              ready_q;
  logic              busy_q;
  logic              wvalid_q;
  logic              accept;
  logic [WIDTH-1:0]  entry_q [ROWS][COLS];

  // A start pulse pre-empts any beat arriving in the same cycle.
  assign accept = wf.i_valid && ready_q && !wf.i_start;

  assign wf.o_ready        = ready_q;
  assign wf.o_busy         = busy_q;
  assign wf.o_weight_valid = wvalid_q;

  // Load sequencing: state, row/col position and state-decoded flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      wvalid_q <= 1'b0;
    end else if (wf.i_start) begin
      state_q  <= LOAD;
      row_q    <= '0;
      col_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b1;
      wvalid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q    <= '0;
                state_q  <= DONE;
                ready_q  <= 1'b0;
                busy_q   <= 1'b0;
                wvalid_q <= 1'b1;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        DONE: begin
          ready_q  <= 1'b0;
          busy_q   <= 1'b0;
          wvalid_q <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b0;
          busy_q   <= 1'b0;
          wvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // One storage register per entry, written when the beat lands on its slot.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic wr_en;
      assign wr_en = accept && (row_q == RW'(r)) && (col_q == CW'(c));
      lib_reg #(.WIDTH(WIDTH)) u_entry (
        .clk (i_clk),
        .rst (i_rst),
        .en  (wr_en),
        .d   (wf.i_data),
        .q   (entry_q[r][c])
      );
    end
  end

  // Flatten the entry registers into the buffer-facing packed array.
  always_comb begin
    wf.o_weight = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        wf.o_weight[r][c] = entry_q[r][c];
      end
    end
  end

endmodule
